// File: rtl/weight_sp_gen.sv
// weight_sp_gen: serial weight transmitter.
// A weight N is sent as N back-to-back segments of 2^CNT_W ones followed by
// GAP_LEN zero cycles. The downstream spike-count decoder recovers N by
// counting complete segments.
//
// Handshake: a weight is taken on a rising edge where w_valid, w_ready and
// sys_en are all high. w_ready is high only in IDLE; w_valid and w_data are
// ignored at every other time, and w_data may change freely after acceptance.
module weight_sp_gen #(
  parameter int CNT_W   = 7,
  parameter int GAP_LEN = 2
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       sys_en,
  input  logic       w_valid,
  input  logic [7:0] w_data,
  output logic       w_ready,
  output logic       data_out,
  output logic       sp_col,
  output logic       done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BIT_LAST = '1;
  localparam logic [3:0]       GAP_LAST = 4'(GAP_LEN - 1);

  state_t           state;
  logic [7:0]       seg_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;

  // Transfer FSM with its counters; done is a one-cycle pulse that clears on
  // the next edge whether or not sys_en is high.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      seg_cnt <= 8'd0;
      bit_cnt <= '0;
      gap_cnt <= 4'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sys_en) begin
        case (state)
          IDLE: begin
            if (w_valid) begin
              seg_cnt <= w_data;
              bit_cnt <= '0;
              gap_cnt <= 4'd0;
              // A zero weight skips straight to the gap so done still fires.
              state   <= (w_data != 8'd0) ? SEND : GAP;
            end
          end
          SEND: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              seg_cnt <= seg_cnt - 8'd1;
              if (seg_cnt == 8'd1) begin
                state   <= GAP;
                gap_cnt <= 4'd0;
              end
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + 4'd1;
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Outputs decode directly from state so reset drops data_out at once.
  always_comb begin
    w_ready   = (state == IDLE);
    data_out  = (state == SEND);
    sp_col    = (state == SEND) && (bit_cnt == BIT_LAST);
    state_dbg = state;
  end

endmodule

// File: tb/tb_weight_sp_gen.sv
// Directed testbench for weight_sp_gen with hand-computed expectations.
module tb_weight_sp_gen;

  localparam int CNT_W   = 7;
  localparam int GAP_LEN = 2;
  localparam int SEG     = 128;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       sys_en  = 1'b0;
  logic       w_valid = 1'b0;
  logic [7:0] w_data  = 8'd0;
  logic       w_ready;
  logic       data_out;
  logic       sp_col;
  logic       done;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  weight_sp_gen #(.CNT_W(CNT_W), .GAP_LEN(GAP_LEN)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .sys_en   (sys_en),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_ready  (w_ready),
    .data_out (data_out),
    .sp_col   (sp_col),
    .done     (done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Bounded wait until the DUT is ready for a new weight.
  task automatic wait_idle();
    int k;
    k = 0;
    while (w_ready !== 1'b1 && k < 40000) begin
      step();
      k++;
    end
    n_cmp++;
    if (w_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wait_idle: w_ready=%b after %0d cycles, required 1", w_ready, k);
    end
  endtask

  // Driver/monitor for one transfer already presented this cycle. Walks the
  // stream cycle by cycle (rel = cycles since acceptance) until done or budget.
  // Optionally drops sys_en for stall_len cycles after the stall_at-th one and
  // optionally keeps w_valid high while ones are being sent.
  task automatic observe(input int budget, input int stall_at, input int stall_len,
                         input bit hold_valid, input logic [7:0] junk,
                         output int ones, output int cols, output int col_bad,
                         output int first_one, output int last_one, output int holes,
                         output int done_rel, output int stall_cyc, output int stall_bad,
                         output int ready_bad);
    int  en_left;
    int  zc;
    bit  frozen;
    bit  stalled;
    ones = 0; cols = 0; col_bad = 0; first_one = -1; last_one = -1; holes = 0;
    done_rel = -1; stall_cyc = 0; stall_bad = 0; ready_bad = 0;
    en_left = 0; zc = 0; frozen = 1'b0; stalled = 1'b0;
    for (int rel = 1; rel <= budget; rel++) begin
      step();
      if (rel == 1) begin
        w_data = junk;
        if (!hold_valid) w_valid = 1'b0;
      end
      if (frozen) begin
        stall_cyc++;
        if (data_out !== 1'b1 || sp_col !== 1'b0) stall_bad++;
      end else begin
        if (data_out === 1'b1) begin
          ones++;
          if (first_one < 0) first_one = rel;
          last_one = rel;
          holes += zc;
          zc = 0;
          if (w_ready !== 1'b0) ready_bad++;
        end else if (first_one >= 0) begin
          zc++;
        end
        if (sp_col === 1'b1) begin
          cols++;
          if (data_out !== 1'b1 || (ones % SEG) != 0) col_bad++;
        end else if (data_out === 1'b1 && (ones % SEG) == 0) begin
          col_bad++;
        end
        if (done === 1'b1) begin
          done_rel = rel;
          sys_en = 1'b1;
          break;
        end
      end
      if (hold_valid && first_one >= 0 && data_out === 1'b0) w_valid = 1'b0;
      if (en_left > 0) begin
        sys_en = 1'b0;
        en_left--;
      end else if (!stalled && stall_len > 0 && ones == stall_at) begin
        sys_en = 1'b0;
        en_left = stall_len - 1;
        stalled = 1'b1;
      end else begin
        sys_en = 1'b1;
      end
      frozen = !sys_en;
    end
    sys_en = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; sys_en = 1'b1; w_valid = 1'b0;
    #12;
    n_cmp++;
    if ({data_out, sp_col, done, w_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_hold: data_out/sp_col/done/w_ready=%b, required 0001",
               {data_out, sp_col, done, w_ready});
    end
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({data_out, sp_col, done, w_ready} !== 4'b0001) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_idle: %0d bad idle cycles, required 0", bad);
    end
    n_cmp++;
    if (state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: state_dbg=%0d, required 0", state_dbg);
    end
  endtask

  task automatic test_single();
    int o, c, cb, f, l, h, d, sc, sb, rb;
    wait_idle();
    w_valid = 1'b1; w_data = 8'd1;
    observe(200, 0, 0, 1'b0, 8'hff, o, c, cb, f, l, h, d, sc, sb, rb);
    n_cmp++;
    if (o != 128 || f != 1 || l != 128 || h != 0) begin
      n_err++;
      $display("FAIL single_ones: ones=%0d first=%0d last=%0d holes=%0d, required 128 1 128 0", o, f, l, h);
    end
    n_cmp++;
    if (c != 1 || cb != 0) begin
      n_err++;
      $display("FAIL single_spcol: pulses=%0d misplaced=%0d, required 1 0", c, cb);
    end
    n_cmp++;
    if (d != 131) begin
      n_err++;
      $display("FAIL single_done: done at T+%0d, required T+131", d);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || w_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_done_pulse: done=%b w_ready=%b, required 0 1", done, w_ready);
    end
  endtask

  task automatic test_zero();
    int o, c, cb, f, l, h, d, sc, sb, rb;
    wait_idle();
    w_valid = 1'b1; w_data = 8'd0;
    observe(20, 0, 0, 1'b0, 8'h55, o, c, cb, f, l, h, d, sc, sb, rb);
    n_cmp++;
    if (o != 0 || c != 0) begin
      n_err++;
      $display("FAIL zero_ones: ones=%0d pulses=%0d, required 0 0", o, c);
    end
    n_cmp++;
    if (d != 3) begin
      n_err++;
      $display("FAIL zero_done: done at T+%0d, required T+3", d);
    end
  endtask

  task automatic test_max();
    int o, c, cb, f, l, h, d, sc, sb, rb;
    wait_idle();
    w_valid = 1'b1; w_data = 8'd255;
    observe(32700, 0, 0, 1'b0, 8'h00, o, c, cb, f, l, h, d, sc, sb, rb);
    n_cmp++;
    if (o != 32640 || h != 0) begin
      n_err++;
      $display("FAIL max_ones: ones=%0d holes=%0d, required 32640 0", o, h);
    end
    n_cmp++;
    if (c != 255 || cb != 0) begin
      n_err++;
      $display("FAIL max_spcol: pulses=%0d misplaced=%0d, required 255 0", c, cb);
    end
    n_cmp++;
    if (d != 32643) begin
      n_err++;
      $display("FAIL max_done: done at T+%0d, required T+32643", d);
    end
  endtask

  task automatic test_back_to_back();
    int o1, c1, cb1, f1, l1, h1, d1, sc, sb, rb;
    int o2, c2, cb2, f2, l2, h2, d2;
    wait_idle();
    w_valid = 1'b1; w_data = 8'd3;
    observe(500, 0, 0, 1'b0, 8'h07, o1, c1, cb1, f1, l1, h1, d1, sc, sb, rb);
    // Present the second weight on the done cycle of the first.
    w_valid = 1'b1; w_data = 8'd2;
    observe(400, 0, 0, 1'b0, 8'h09, o2, c2, cb2, f2, l2, h2, d2, sc, sb, rb);
    n_cmp++;
    if (o1 != 384 || c1 != 3 || cb1 != 0 || d1 != 387) begin
      n_err++;
      $display("FAIL b2b_first: ones=%0d pulses=%0d misplaced=%0d done=T+%0d, required 384 3 0 T+387",
               o1, c1, cb1, d1);
    end
    n_cmp++;
    if (d1 - l1 - 1 != GAP_LEN) begin
      n_err++;
      $display("FAIL b2b_gap: %0d zeros after first run, required %0d", d1 - l1 - 1, GAP_LEN);
    end
    n_cmp++;
    if (f2 != 1 || o2 != 256 || c2 != 2 || d2 != 259) begin
      n_err++;
      $display("FAIL b2b_second: first_one=T+%0d ones=%0d pulses=%0d done=T+%0d, required 1 256 2 T+259",
               f2, o2, c2, d2);
    end
    n_cmp++;
    if ((d1 > 0 ? 1 : 0) + (d2 > 0 ? 1 : 0) != 2) begin
      n_err++;
      $display("FAIL b2b_dones: done pulses=%0d, required 2", (d1 > 0 ? 1 : 0) + (d2 > 0 ? 1 : 0));
    end
  endtask

  task automatic test_stall();
    int o, c, cb, f, l, h, d, sc, sb, rb;
    wait_idle();
    w_valid = 1'b1; w_data = 8'd2;
    observe(400, 60, 5, 1'b1, 8'h00, o, c, cb, f, l, h, d, sc, sb, rb);
    n_cmp++;
    if (sc != 5 || sb != 0) begin
      n_err++;
      $display("FAIL stall_hold: frozen=%0d bad_frozen=%0d, required 5 0", sc, sb);
    end
    n_cmp++;
    if (o != 256 || c != 2 || cb != 0) begin
      n_err++;
      $display("FAIL stall_ones: ones=%0d pulses=%0d misplaced=%0d, required 256 2 0", o, c, cb);
    end
    n_cmp++;
    if (d != 264) begin
      n_err++;
      $display("FAIL stall_done: done at T+%0d, required T+264", d);
    end
    n_cmp++;
    if (rb != 0) begin
      n_err++;
      $display("FAIL stall_ready: w_ready high on %0d SEND cycles, required 0", rb);
    end
  endtask

  task automatic test_reset_mid_run();
    int o, c, cb, f, l, h, d, sc, sb, rb;
    int bad;
    wait_idle();
    w_valid = 1'b1; w_data = 8'd4;
    observe(300, 0, 0, 1'b0, 8'h00, o, c, cb, f, l, h, d, sc, sb, rb);
    n_cmp++;
    if (o != 300 || data_out !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: ones=%0d data_out=%b, required 300 1", o, data_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data_out, sp_col, done, w_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_mid_async: data_out/sp_col/done/w_ready=%b, required 0001",
               {data_out, sp_col, done, w_ready});
    end
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done !== 1'b0 || data_out !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL rst_mid_quiet: %0d cycles with done or data_out, required 0", bad);
    end
    w_valid = 1'b1; w_data = 8'd1;
    observe(200, 0, 0, 1'b0, 8'h00, o, c, cb, f, l, h, d, sc, sb, rb);
    n_cmp++;
    if (o != 128 || c != 1 || h != 0 || d != 131) begin
      n_err++;
      $display("FAIL rst_mid_fresh: ones=%0d pulses=%0d holes=%0d done=T+%0d, required 128 1 0 T+131",
               o, c, h, d);
    end
  endtask

  task automatic test_loopback();
    int o, c, cb, f, l, h, d, sc, sb, rb;
    int dec_cnt;
    wait_idle();
    w_valid = 1'b1; w_data = 8'd37;
    observe(5000, 0, 0, 1'b0, 8'h00, o, c, cb, f, l, h, d, sc, sb, rb);
    // Decoder model: complete segments in one unbroken run of ones.
    dec_cnt = (h == 0 && (o % SEG) == 0) ? (o >> CNT_W) : -1;
    n_cmp++;
    if (dec_cnt != 37) begin
      n_err++;
      $display("FAIL loopback_count: decoder=%0d, required 37", dec_cnt);
    end
    n_cmp++;
    if (d != 37 * SEG + GAP_LEN + 1) begin
      n_err++;
      $display("FAIL loopback_done: done at T+%0d, required T+%0d", d, 37 * SEG + GAP_LEN + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero();
    test_max();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
